// File: rtl/pipe_ctrl_tracker_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_tracker_pkg
//   Shared types and constants for the pipeline-control tracker.
//   - WB_DATA_ALU / WB_DATA_MEM : write-back data source select values
//   - ctrl_bundle_t             : 10-bit control bundle carried EXE -> MEM
//   - wb_bundle_t               : register-file subset carried into WB
//   - make_bundle()             : packs decode fields into a bundle
// ---------------------------------------------------------------------------
package pipe_ctrl_tracker_pkg;

  localparam logic WB_DATA_ALU = 1'b0;
  localparam logic WB_DATA_MEM = 1'b1;

  localparam int REG_ADDR_W   = 5;
  localparam int BUNDLE_W     = 10;
  localparam int WB_BUNDLE_W  = 7;

  // Field order matches the datapath latch layout:
  // {is_branch, wb_wen, wb_addr[4:0], wb_data_src, mem_ren, mem_wen}
  typedef struct packed {
    logic                  is_branch;
    logic                  wb_wen;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic                  wb_data_src;
    logic                  mem_ren;
    logic                  mem_wen;
  } ctrl_bundle_t;

  // WB only drives the register file, so only these fields travel that far.
  typedef struct packed {
    logic                  wb_wen;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic                  wb_data_src;
  } wb_bundle_t;

  // Register 0 is hardwired, so a write aimed at it is captured as a
  // non-write; downstream hazard logic then never stalls on r0.
  function automatic ctrl_bundle_t make_bundle(
    input logic                  is_branch,
    input logic                  wb_wen,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic                  wb_data_src,
    input logic                  mem_ren,
    input logic                  mem_wen
  );
    ctrl_bundle_t b;
    b.is_branch   = is_branch;
    b.wb_wen      = wb_wen & (wb_addr != '0);
    b.wb_addr     = wb_addr;
    b.wb_data_src = wb_data_src;
    b.mem_ren     = mem_ren;
    b.mem_wen     = mem_wen;
    return b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_tracker_stage.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_stage
//   One pipeline stage of control state: a valid bit plus a W-bit bundle.
//   Update priority on each clock edge: rst > stage_rst > stage_en > hold.
// Ports
//   clk, rst            clock, synchronous active-high global reset
//   stage_rst           load a bubble (valid=0, bundle=0)
//   stage_en            load in_valid/in_bundle
//   in_valid, in_bundle contents of the upstream stage (or decode)
//   out_valid,out_bundle registered stage contents
// ---------------------------------------------------------------------------
module pipe_ctrl_stage
  import pipe_ctrl_tracker_pkg::*;
#(
  parameter int W = BUNDLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stage_rst,
  input  logic         stage_en,
  input  logic         in_valid,
  input  logic [W-1:0] in_bundle,
  output logic         out_valid,
  output logic [W-1:0] out_bundle
);

  logic         r_valid;
  logic [W-1:0] r_bundle;

  // A stage reset inserts a bubble even while the stage is frozen, so a
  // squash always wins over a stall. With neither asserted, stage_en=0
  // keeps the current instruction in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
    end else if (stage_rst) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
    end else if (stage_en) begin
      r_valid  <= in_valid;
      r_bundle <= in_bundle;
    end
  end

  assign out_valid  = r_valid;
  assign out_bundle = r_bundle;

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_tracker
//   Responder side of the pipeline-control interface. Tracks per-stage
//   valid flags and the decoded control bundle through ID->EXE->MEM->WB,
//   obeying the controller's per-stage reset/enable, and returns the hazard
//   feedback (branch, write address/enable, data source) for EXE and MEM.
// Parameters
//   CNT_W                 width of the saturating retired-instruction counter
// Ports
//   clk, rst              clock, synchronous active-high reset
//   if_/id_/exe_/mem_/wb_ rst,en   per-stage reset/enable from controller
//   dec_*                 decoded control fields from ID
//   *_valid               stage valid flags
//   *_exe, *_mem          valid-qualified hazard feedback
//   mem_ren_mem/mem_wen_mem  valid-qualified memory strobes
//   wb_wen_wb, regw_addr_wb, wb_data_src_wb  register-file write controls
//   retired_cnt           valid instructions leaving WB (saturating)
// All outputs are registers or an AND of registers: no input-to-output path.
// ---------------------------------------------------------------------------
module pipe_ctrl_tracker
  import pipe_ctrl_tracker_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_rst,
  input  logic                  if_en,
  input  logic                  id_rst,
  input  logic                  id_en,
  input  logic                  exe_rst,
  input  logic                  exe_en,
  input  logic                  mem_rst,
  input  logic                  mem_en,
  input  logic                  wb_rst,
  input  logic                  wb_en,
  input  logic                  dec_wb_wen,
  input  logic [REG_ADDR_W-1:0] dec_wb_addr,
  input  logic                  dec_wb_data_src,
  input  logic                  dec_mem_ren,
  input  logic                  dec_mem_wen,
  input  logic                  dec_is_branch,
  output logic                  if_valid,
  output logic                  id_valid,
  output logic                  exe_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic                  is_branch_exe,
  output logic                  wb_wen_exe,
  output logic                  wb_data_src_exe,
  output logic [REG_ADDR_W-1:0] regw_addr_exe,
  output logic                  is_branch_mem,
  output logic                  wb_wen_mem,
  output logic                  wb_data_src_mem,
  output logic [REG_ADDR_W-1:0] regw_addr_mem,
  output logic                  mem_ren_mem,
  output logic                  mem_wen_mem,
  output logic                  wb_wen_wb,
  output logic [REG_ADDR_W-1:0] regw_addr_wb,
  output logic                  wb_data_src_wb,
  output logic [CNT_W-1:0]      retired_cnt
);

  logic         r_if_valid;
  logic         r_id_valid;
  logic [CNT_W-1:0] r_retired_cnt;

  ctrl_bundle_t w_dec_bundle;
  ctrl_bundle_t w_exe_bundle;
  ctrl_bundle_t w_mem_bundle;
  wb_bundle_t   w_mem_to_wb;
  wb_bundle_t   w_wb_bundle;
  logic         w_exe_valid;
  logic         w_mem_valid;
  logic         w_wb_valid;
  logic         w_retire;

  // IF has no upstream: an enabled IF always holds a fetched instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
    end else if (if_rst) begin
      r_if_valid <= 1'b0;
    end else if (if_en) begin
      r_if_valid <= 1'b1;
    end
  end

  // ID inherits IF's valid; a bubble from id_rst beats a stall on id_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid <= 1'b0;
    end else if (id_rst) begin
      r_id_valid <= 1'b0;
    end else if (id_en) begin
      r_id_valid <= r_if_valid;
    end
  end

  assign w_dec_bundle = make_bundle(dec_is_branch, dec_wb_wen, dec_wb_addr,
                                    dec_wb_data_src, dec_mem_ren, dec_mem_wen);

  pipe_ctrl_stage #(.W(BUNDLE_W)) u_exe (
    .clk        (clk),
    .rst        (rst),
    .stage_rst  (exe_rst),
    .stage_en   (exe_en),
    .in_valid   (r_id_valid),
    .in_bundle  (w_dec_bundle),
    .out_valid  (w_exe_valid),
    .out_bundle (w_exe_bundle)
  );

  pipe_ctrl_stage #(.W(BUNDLE_W)) u_mem (
    .clk        (clk),
    .rst        (rst),
    .stage_rst  (mem_rst),
    .stage_en   (mem_en),
    .in_valid   (w_exe_valid),
    .in_bundle  (w_exe_bundle),
    .out_valid  (w_mem_valid),
    .out_bundle (w_mem_bundle)
  );

  assign w_mem_to_wb.wb_wen      = w_mem_bundle.wb_wen;
  assign w_mem_to_wb.wb_addr     = w_mem_bundle.wb_addr;
  assign w_mem_to_wb.wb_data_src = w_mem_bundle.wb_data_src;

  pipe_ctrl_stage #(.W(WB_BUNDLE_W)) u_wb (
    .clk        (clk),
    .rst        (rst),
    .stage_rst  (wb_rst),
    .stage_en   (wb_en),
    .in_valid   (w_mem_valid),
    .in_bundle  (w_mem_to_wb),
    .out_valid  (w_wb_valid),
    .out_bundle (w_wb_bundle)
  );

  // An instruction retires when WB advances with valid contents; this uses
  // the current WB valid, i.e. the instruction leaving the stage.
  assign w_retire = wb_en & ~wb_rst & w_wb_valid;

  // Counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_cnt <= '0;
    end else if (w_retire && (r_retired_cnt != {CNT_W{1'b1}})) begin
      r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  assign if_valid  = r_if_valid;
  assign id_valid  = r_id_valid;
  assign exe_valid = w_exe_valid;
  assign mem_valid = w_mem_valid;
  assign wb_valid  = w_wb_valid;

  // Feedback is gated by stage valid so a stalled-out or squashed slot
  // never looks like a hazard to the controller.
  assign is_branch_exe   = w_exe_valid & w_exe_bundle.is_branch;
  assign wb_wen_exe      = w_exe_valid & w_exe_bundle.wb_wen;
  assign wb_data_src_exe = w_exe_valid & w_exe_bundle.wb_data_src;
  assign regw_addr_exe   = w_exe_valid ? w_exe_bundle.wb_addr : '0;

  assign is_branch_mem   = w_mem_valid & w_mem_bundle.is_branch;
  assign wb_wen_mem      = w_mem_valid & w_mem_bundle.wb_wen;
  assign wb_data_src_mem = w_mem_valid & w_mem_bundle.wb_data_src;
  assign regw_addr_mem   = w_mem_valid ? w_mem_bundle.wb_addr : '0;
  assign mem_ren_mem     = w_mem_valid & w_mem_bundle.mem_ren;
  assign mem_wen_mem     = w_mem_valid & w_mem_bundle.mem_wen;

  assign wb_wen_wb       = w_wb_valid & w_wb_bundle.wb_wen;
  assign regw_addr_wb    = w_wb_valid ? w_wb_bundle.wb_addr : '0;
  assign wb_data_src_wb  = w_wb_valid & w_wb_bundle.wb_data_src;

  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_tracker
//   Directed and random stimulus against a slot-based reference model of the
//   five-stage control pipeline. A second instance with a 4-bit counter
//   exercises saturation.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_tracker;

  logic clk;
  logic rst;
  logic ifRst, ifEn, idRst, idEn, exeRst, exeEn, memRst, memEn, wbRst, wbEn;
  logic decWbWen, decWbSrc, decMemRen, decMemWen, decIsBranch;
  logic [4:0] decWbAddr;

  logic ifValid, idValid, exeValid, memValid, wbValid;
  logic isBranchExe, wbWenExe, wbSrcExe;
  logic [4:0] regwAddrExe;
  logic isBranchMem, wbWenMem, wbSrcMem, memRenMem, memWenMem;
  logic [4:0] regwAddrMem;
  logic wbWenWb, wbSrcWb;
  logic [4:0] regwAddrWb;
  logic [31:0] retiredCnt;
  logic [3:0]  retiredCnt4;
  logic [29:0] sink4;

  int total;
  int bad;
  int cycle;

  // Reference model: each stage is a slot holding an instruction or nothing.
  typedef struct {
    bit       v;
    bit       br;
    bit       wen;
    bit [4:0] addr;
    bit       src;
    bit       ren;
    bit       mwen;
  } slot_t;

  slot_t pipe [5];
  int    modelRetired;
  int    modelRetired4;

  pipe_ctrl_tracker #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_rst(ifRst), .if_en(ifEn), .id_rst(idRst), .id_en(idEn),
    .exe_rst(exeRst), .exe_en(exeEn), .mem_rst(memRst), .mem_en(memEn),
    .wb_rst(wbRst), .wb_en(wbEn),
    .dec_wb_wen(decWbWen), .dec_wb_addr(decWbAddr), .dec_wb_data_src(decWbSrc),
    .dec_mem_ren(decMemRen), .dec_mem_wen(decMemWen), .dec_is_branch(decIsBranch),
    .if_valid(ifValid), .id_valid(idValid), .exe_valid(exeValid),
    .mem_valid(memValid), .wb_valid(wbValid),
    .is_branch_exe(isBranchExe), .wb_wen_exe(wbWenExe),
    .wb_data_src_exe(wbSrcExe), .regw_addr_exe(regwAddrExe),
    .is_branch_mem(isBranchMem), .wb_wen_mem(wbWenMem),
    .wb_data_src_mem(wbSrcMem), .regw_addr_mem(regwAddrMem),
    .mem_ren_mem(memRenMem), .mem_wen_mem(memWenMem),
    .wb_wen_wb(wbWenWb), .regw_addr_wb(regwAddrWb), .wb_data_src_wb(wbSrcWb),
    .retired_cnt(retiredCnt)
  );

  pipe_ctrl_tracker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .if_rst(ifRst), .if_en(ifEn), .id_rst(idRst), .id_en(idEn),
    .exe_rst(exeRst), .exe_en(exeEn), .mem_rst(memRst), .mem_en(memEn),
    .wb_rst(wbRst), .wb_en(wbEn),
    .dec_wb_wen(decWbWen), .dec_wb_addr(decWbAddr), .dec_wb_data_src(decWbSrc),
    .dec_mem_ren(decMemRen), .dec_mem_wen(decMemWen), .dec_is_branch(decIsBranch),
    .if_valid(sink4[0]), .id_valid(sink4[1]), .exe_valid(sink4[2]),
    .mem_valid(sink4[3]), .wb_valid(sink4[4]),
    .is_branch_exe(sink4[5]), .wb_wen_exe(sink4[6]),
    .wb_data_src_exe(sink4[7]), .regw_addr_exe(sink4[12:8]),
    .is_branch_mem(sink4[13]), .wb_wen_mem(sink4[14]),
    .wb_data_src_mem(sink4[15]), .regw_addr_mem(sink4[20:16]),
    .mem_ren_mem(sink4[21]), .mem_wen_mem(sink4[22]),
    .wb_wen_wb(sink4[23]), .regw_addr_wb(sink4[28:24]), .wb_data_src_wb(sink4[29]),
    .retired_cnt(retiredCnt4)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode word layout used by the bench: {br, wen, addr[4:0], src, ren, mwen}
  function automatic logic [9:0] mkDec(input bit br, input bit wen, input bit [4:0] addr,
                                       input bit src, input bit ren, input bit mwen);
    return {br, wen, addr, src, ren, mwen};
  endfunction

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Advance the model one clock using the inputs currently applied.
  task automatic modelUpdate;
    slot_t nxt [5];
    slot_t inc;
    slot_t zero;
    bit stRst [5];
    bit stEn  [5];
    zero = '{default: 0};
    stRst = '{ifRst, idRst, exeRst, memRst, wbRst};
    stEn  = '{ifEn, idEn, exeEn, memEn, wbEn};
    if (rst) begin
      for (int s = 0; s < 5; s++) pipe[s] = zero;
      modelRetired  = 0;
      modelRetired4 = 0;
      return;
    end
    if (wbEn && !wbRst && pipe[4].v) begin
      modelRetired++;
      if (modelRetired4 < 15) modelRetired4++;
    end
    for (int s = 0; s < 5; s++) begin
      inc = zero;
      if (s == 0) begin
        inc.v = 1'b1;
      end else if (s == 1) begin
        inc.v = pipe[0].v;
      end else if (s == 2) begin
        inc.v    = pipe[1].v;
        inc.br   = decIsBranch;
        inc.wen  = decWbWen && (decWbAddr != 0);
        inc.addr = decWbAddr;
        inc.src  = decWbSrc;
        inc.ren  = decMemRen;
        inc.mwen = decMemWen;
      end else begin
        inc = pipe[s-1];
      end
      if (stRst[s])     nxt[s] = zero;
      else if (stEn[s]) nxt[s] = inc;
      else              nxt[s] = pipe[s];
    end
    for (int s = 0; s < 5; s++) pipe[s] = nxt[s];
  endtask

  task automatic checkAll;
    logic [7:0] expExe;
    logic [9:0] expMem;
    logic [6:0] expWb;
    expExe = pipe[2].v ? {pipe[2].br, pipe[2].wen, pipe[2].src, pipe[2].addr} : 8'd0;
    expMem = pipe[3].v ? {pipe[3].br, pipe[3].wen, pipe[3].src, pipe[3].ren,
                          pipe[3].mwen, pipe[3].addr} : 10'd0;
    expWb  = pipe[4].v ? {pipe[4].wen, pipe[4].src, pipe[4].addr} : 7'd0;
    checkOutput("valids", {27'd0, wbValid, memValid, exeValid, idValid, ifValid},
                {27'd0, pipe[4].v, pipe[3].v, pipe[2].v, pipe[1].v, pipe[0].v});
    checkOutput("exe_fb", {24'd0, isBranchExe, wbWenExe, wbSrcExe, regwAddrExe}, {24'd0, expExe});
    checkOutput("mem_fb", {22'd0, isBranchMem, wbWenMem, wbSrcMem, memRenMem, memWenMem,
                           regwAddrMem}, {22'd0, expMem});
    checkOutput("wb_out", {25'd0, wbWenWb, wbSrcWb, regwAddrWb}, {25'd0, expWb});
    checkOutput("retired", retiredCnt, modelRetired);
    checkOutput("retired4", {28'd0, retiredCnt4}, modelRetired4);
  endtask

  // Apply one cycle of controls and decode, clock once, then compare.
  // Bit order of stRst/stEn: [0]=IF [1]=ID [2]=EXE [3]=MEM [4]=WB.
  task automatic applyStimulus(input logic [4:0] stRst, input logic [4:0] stEn,
                               input logic [9:0] dec);
    {wbRst, memRst, exeRst, idRst, ifRst} = stRst;
    {wbEn, memEn, exeEn, idEn, ifEn}      = stEn;
    {decIsBranch, decWbWen, decWbAddr, decWbSrc, decMemRen, decMemWen} = dec;
    @(posedge clk);
    modelUpdate();
    cycle++;
    #1;
    checkAll();
  endtask

  function automatic logic [9:0] randDec;
    return 10'($urandom);
  endfunction

  localparam logic [4:0] ALL = 5'h1f;
  localparam logic [4:0] NONE = 5'h00;

  initial begin
    logic [9:0] nop, addR3, lwR2, depR4, wrR0;
    logic [4:0] rr, ee;
    total = 0;
    bad   = 0;
    cycle = 0;
    modelRetired  = 0;
    modelRetired4 = 0;
    for (int s = 0; s < 5; s++) pipe[s] = '{default: 0};
    nop   = mkDec(0, 0, 5'd0, 0, 0, 0);
    addR3 = mkDec(0, 1, 5'd3, 0, 0, 0);
    lwR2  = mkDec(0, 1, 5'd2, 1, 1, 0);
    depR4 = mkDec(0, 1, 5'd4, 0, 0, 0);
    wrR0  = mkDec(0, 1, 5'd0, 0, 0, 0);

    // Reset held with all enables high: everything stays cleared.
    rst = 1'b1;
    repeat (3) applyStimulus(NONE, ALL, nop);
    checkOutput("rst_if_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("rst_cnt", retiredCnt, 32'd0);
    rst = 1'b0;

    // Fill, then ADD r3 walks EXE -> MEM -> WB.
    applyStimulus(NONE, ALL, nop);
    checkOutput("first_if_valid", {31'd0, ifValid}, 32'd1);
    applyStimulus(NONE, ALL, nop);
    applyStimulus(NONE, ALL, addR3);
    checkOutput("add_exe", {26'd0, wbWenExe, regwAddrExe}, {26'd0, 1'b1, 5'd3});
    applyStimulus(NONE, ALL, nop);
    checkOutput("add_mem", {26'd0, wbWenMem, regwAddrMem}, {26'd0, 1'b1, 5'd3});
    applyStimulus(NONE, ALL, nop);
    checkOutput("add_wb", {26'd0, wbWenWb, regwAddrWb}, {26'd0, 1'b1, 5'd3});
    checkOutput("wb_valid_c5", {31'd0, wbValid}, 32'd1);
    repeat (2) applyStimulus(NONE, ALL, nop);

    // Load-use stall: LW r2 in EXE, then IF/ID hold and EXE takes a bubble.
    applyStimulus(NONE, ALL, lwR2);
    applyStimulus(5'b00100, 5'b11100, depR4);
    checkOutput("stall_exe_valid", {31'd0, exeValid}, 32'd0);
    checkOutput("stall_mem_lw", {25'd0, wbWenMem, wbSrcMem, regwAddrMem}, {25'd0, 1'b1, 1'b1, 5'd2});
    applyStimulus(NONE, ALL, depR4);
    checkOutput("dep_exe", {26'd0, wbWenExe, regwAddrExe}, {26'd0, 1'b1, 5'd4});
    repeat (3) applyStimulus(NONE, ALL, nop);

    // Full freeze for four cycles, then resume.
    applyStimulus(NONE, ALL, addR3);
    repeat (4) applyStimulus(NONE, NONE, randDec());
    repeat (4) applyStimulus(NONE, ALL, nop);

    // Squash ID while it is stalled.
    applyStimulus(5'b00010, 5'b11101, nop);
    checkOutput("idrst_id_valid", {31'd0, idValid}, 32'd0);
    repeat (5) applyStimulus(NONE, ALL, nop);

    // Write to r0 reaches WB as a non-write.
    applyStimulus(NONE, ALL, wrR0);
    repeat (2) applyStimulus(NONE, ALL, nop);
    checkOutput("r0_wb_valid", {31'd0, wbValid}, 32'd1);
    checkOutput("r0_wb_wen", {31'd0, wbWenWb}, 32'd0);

    // Enough retirements to saturate the 4-bit counter.
    repeat (25) applyStimulus(NONE, ALL, randDec());
    checkOutput("cnt4_sat", {28'd0, retiredCnt4}, 32'd15);

    // Random controls, decode and occasional global reset.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int s = 0; s < 5; s++) begin
        rr[s] = ($urandom_range(0, 11) == 0);
        ee[s] = ($urandom_range(0, 7) != 0);
      end
      applyStimulus(rr, ee, randDec());
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
